// File: rtl/uc_pkg.sv
// Shared definitions for the uc_multicycle control unit.
// Contents:
//   state_e    - FSM states. The numeric codes are visible on the debug port.
//   op_class_e - instruction classes that the opcode decoder produces.
//   OP_*       - RV64 major opcodes (instr[6:0]) that this unit accepts.
//   ALU_*      - alu_cmd encodings that the datapath ALU understands.
//   classify   - maps an opcode to its class. Unknown opcodes map to CLS_ILLEGAL.
package uc_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_R       = 3'd1,
    CLS_I       = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;

  function automatic op_class_e classify(input logic [6:0] op);
    op_class_e c;
    case (op)
      OP_R:      c = CLS_R;
      OP_I:      c = CLS_I;
      OP_LOAD:   c = CLS_LOAD;
      OP_STORE:  c = CLS_STORE;
      OP_BRANCH: c = CLS_BRANCH;
      default:   c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode-to-class decoder.
// Ports:
//   opcode_i   [6:0] - instr[6:0] from the datapath
//   op_class_o       - decoded instruction class (CLS_ILLEGAL for unknown opcodes)
module opcode_decoder
  import uc_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_e  op_class_o
);

  assign op_class_o = classify(opcode_i);

endmodule

// File: rtl/uc_multicycle.sv
// Multi-cycle control unit for the RV64 datapath.
// Each instruction steps through FETCH/DECODE/EXECUTE/MEM/WB. The number of
// cycles an instruction takes depends on its opcode class.
// Ports:
//   clk, rst_n     - clock (rising edge) and asynchronous active-low reset
//   run            - level qualifier, sampled only in FETCH. While it is low
//                    no new instruction starts. An instruction that has
//                    already started always runs to completion.
//   opcode         - instr[6:0]. It is sampled only in DECODE.
//   alu_flags      - datapath ALU flags. Bit 0 (equal) selects the branch target.
//   d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src - datapath controls
//   pc_we          - one-cycle PC update strobe, raised in the last cycle
//                    of every legal instruction
//   illegal        - high while the unit is parked in HALT
//   retired        - count of completed instructions. It wraps silently.
//   state_o        - current FSM state, for debug
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic [3:0]           alu_flags,
  output logic                 d_mem_we,
  output logic                 rf_we,
  output logic [3:0]           alu_cmd,
  output logic                 alu_src,
  output logic                 pc_src,
  output logic                 rf_src,
  output logic                 pc_we,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [2:0]           state_o
);

  state_e               state_q, state_d;
  op_class_e            cls_q, cls_d;
  op_class_e            dec_cls;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  // Only the equal flag affects control. The other flags are deliberately ignored.
  logic unused_flags;
  assign unused_flags = ^alu_flags[3:1];

  opcode_decoder u_opcode_decoder (
    .opcode_i   (opcode),
    .op_class_o (dec_cls)
  );

  // State, latched class and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      cls_q     <= CLS_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      FETCH: begin
        if (run) state_d = DECODE;
      end
      DECODE: begin
        cls_d   = dec_cls;
        state_d = (dec_cls == CLS_ILLEGAL) ? HALT : EXECUTE;
      end
      EXECUTE: begin
        case (cls_q)
          CLS_BRANCH:          state_d = FETCH;
          CLS_LOAD, CLS_STORE: state_d = MEM;
          CLS_R, CLS_I:        state_d = WB;
          // A class that cannot legally reach EXECUTE parks the unit.
          default:             state_d = HALT;
        endcase
      end
      MEM: begin
        state_d = (cls_q == CLS_LOAD) ? WB : FETCH;
      end
      WB: begin
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // The outputs are a Moore function of (state, latched class). The one
  // exception is pc_src, which follows the live equal flag while a branch
  // executes.
  always_comb begin
    d_mem_we  = 1'b0;
    rf_we     = 1'b0;
    alu_cmd   = ALU_ADD;
    alu_src   = 1'b0;
    pc_src    = 1'b0;
    rf_src    = 1'b0;
    pc_we     = 1'b0;
    retired_d = retired_q;

    // EXECUTE, MEM and WB all drive the same ALU operands and command, so
    // the address or result stays stable while it is consumed.
    if (state_q == EXECUTE || state_q == MEM || state_q == WB) begin
      alu_src = (cls_q == CLS_I) || (cls_q == CLS_LOAD) || (cls_q == CLS_STORE);
      case (cls_q)
        CLS_BRANCH:          alu_cmd = ALU_SUB;
        CLS_LOAD, CLS_STORE: alu_cmd = ALU_ADD;
        CLS_R, CLS_I:        alu_cmd = ALU_FUNCT;
        default:             alu_cmd = ALU_ADD;
      endcase
    end

    case (state_q)
      EXECUTE: begin
        if (cls_q == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = alu_flags[0];
        end
      end
      MEM: begin
        if (cls_q == CLS_STORE) begin
          d_mem_we = 1'b1;
          pc_we    = 1'b1;
        end
      end
      WB: begin
        rf_we  = 1'b1;
        rf_src = (cls_q == CLS_LOAD);
        pc_we  = 1'b1;
      end
      default: ;
    endcase

    if (pc_we) retired_d = retired_q + CNT_WIDTH'(1);
  end

  // HALT can only be left through reset, so decoding it directly gives a sticky flag.
  assign illegal = (state_q == HALT);
  assign retired = retired_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_uc_multicycle.sv
// Testbench for uc_multicycle. It uses CNT_WIDTH=4 so the retired counter
// wraps within a short run.
module tb_uc_multicycle;

  localparam int CW = 4;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] XX_OP = 7'b1111111;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic [6:0]    opcode;
  logic [3:0]    alu_flags;
  logic          d_mem_we, rf_we, alu_src, pc_src, rf_src, pc_we, illegal;
  logic [3:0]    alu_cmd;
  logic [CW-1:0] retired;
  logic [2:0]    state_o;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q[$];

  uc_multicycle #(.CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .opcode    (opcode),
    .alu_flags (alu_flags),
    .d_mem_we  (d_mem_we),
    .rf_we     (rf_we),
    .alu_cmd   (alu_cmd),
    .alu_src   (alu_src),
    .pc_src    (pc_src),
    .rf_src    (rf_src),
    .pc_we     (pc_we),
    .illegal   (illegal),
    .retired   (retired),
    .state_o   (state_o)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic [6:0] op;
    logic [3:0] flags;
    logic [2:0] st;
    logic       dwe;
    logic       rwe;
    logic [3:0] cmd;
    logic       asrc;
    logic       psrc;
    logic       rsrc;
    logic       pwe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic [6:0] op, input logic [3:0] fl,
                             input logic [2:0] st, input logic dwe, input logic rwe,
                             input logic [3:0] cmd, input logic asrc, input logic psrc,
                             input logic rsrc, input logic pwe);
    vec_t x;
    x.run = r; x.op = op; x.flags = fl; x.st = st; x.dwe = dwe; x.rwe = rwe;
    x.cmd = cmd; x.asrc = asrc; x.psrc = psrc; x.rsrc = rsrc; x.pwe = pwe;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compares every output against the given expected values.
  task automatic chk_all(input string tag, input logic [2:0] st, input logic dwe,
                         input logic rwe, input logic [3:0] cmd, input logic asrc,
                         input logic psrc, input logic rsrc, input logic pwe,
                         input logic ill, input logic [CW-1:0] ret);
    chk({tag, " state"},    32'(state_o),  32'(st));
    chk({tag, " d_mem_we"}, 32'(d_mem_we), 32'(dwe));
    chk({tag, " rf_we"},    32'(rf_we),    32'(rwe));
    chk({tag, " alu_cmd"},  32'(alu_cmd),  32'(cmd));
    chk({tag, " alu_src"},  32'(alu_src),  32'(asrc));
    chk({tag, " pc_src"},   32'(pc_src),   32'(psrc));
    chk({tag, " rf_src"},   32'(rf_src),   32'(rsrc));
    chk({tag, " pc_we"},    32'(pc_we),    32'(pwe));
    chk({tag, " illegal"},  32'(illegal),  32'(ill));
    chk({tag, " retired"},  32'(retired),  32'(ret));
  endtask

  // Driver: applies inputs on the falling edge.
  task automatic drive(input logic r, input logic [6:0] op, input logic [3:0] fl);
    @(negedge clk);
    run = r; opcode = op; alu_flags = fl;
  endtask

  logic [CW-1:0] exp_ret;

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = '0; alu_flags = '0;
    exp_ret = '0;

    // Reset state.
    @(negedge clk); #1;
    chk_all("reset", 3'd0, 0, 0, 4'd0, 0, 0, 0, 0, 0, '0);
    rst_n = 1'b1;

    // Per-cycle vectors. The columns are:
    //   run, opcode, flags | state, dwe, rwe, cmd, asrc, psrc, rsrc, pwe
    // The opcode matters only in DECODE rows. Other rows carry junk to show
    // that it is ignored there.
    // R-type: 4 cycles.
    vecs.push_back(v(1, R_OP,  4'h0, 3'd0, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, R_OP,  4'h0, 3'd1, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, XX_OP, 4'h1, 3'd2, 0,0,4'd2,0,0,0,0));
    vecs.push_back(v(1, XX_OP, 4'h0, 3'd4, 0,1,4'd2,0,0,0,1));
    // LOAD: 5 cycles.
    vecs.push_back(v(1, XX_OP, 4'h0, 3'd0, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, LD_OP, 4'h0, 3'd1, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, XX_OP, 4'h0, 3'd2, 0,0,4'd0,1,0,0,0));
    vecs.push_back(v(1, XX_OP, 4'h0, 3'd3, 0,0,4'd0,1,0,0,0));
    vecs.push_back(v(1, XX_OP, 4'h0, 3'd4, 0,1,4'd0,1,0,1,1));
    // STORE: 4 cycles.
    vecs.push_back(v(1, ST_OP, 4'h0, 3'd0, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, ST_OP, 4'h0, 3'd1, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, ST_OP, 4'h0, 3'd2, 0,0,4'd0,1,0,0,0));
    vecs.push_back(v(1, ST_OP, 4'h0, 3'd3, 1,0,4'd0,1,0,0,1));
    // BRANCH with equal set: 3 cycles, pc_src=1.
    vecs.push_back(v(1, BR_OP, 4'h1, 3'd0, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, BR_OP, 4'h1, 3'd1, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, BR_OP, 4'h1, 3'd2, 0,0,4'd1,0,1,0,1));
    // BRANCH with equal clear: pc_src=0.
    vecs.push_back(v(1, BR_OP, 4'hE, 3'd0, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, BR_OP, 4'hE, 3'd1, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, BR_OP, 4'hE, 3'd2, 0,0,4'd1,0,0,0,1));
    // I-type: 4 cycles with the immediate operand.
    vecs.push_back(v(1, I_OP,  4'h0, 3'd0, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, I_OP,  4'h0, 3'd1, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, XX_OP, 4'h0, 3'd2, 0,0,4'd2,1,0,0,0));
    vecs.push_back(v(1, XX_OP, 4'h0, 3'd4, 0,1,4'd2,1,0,0,1));
    // R-type with run dropped mid-instruction: it completes, then the FSM holds in FETCH.
    vecs.push_back(v(1, R_OP,  4'h0, 3'd0, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(1, R_OP,  4'h0, 3'd1, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(0, R_OP,  4'h0, 3'd2, 0,0,4'd2,0,0,0,0));
    vecs.push_back(v(0, R_OP,  4'h0, 3'd4, 0,1,4'd2,0,0,0,1));
    vecs.push_back(v(0, R_OP,  4'h0, 3'd0, 0,0,4'd0,0,0,0,0));
    vecs.push_back(v(0, R_OP,  4'h0, 3'd0, 0,0,4'd0,0,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].run, vecs[i].op, vecs[i].flags);
      #1;
      chk_all($sformatf("row%0d", i), vecs[i].st, vecs[i].dwe, vecs[i].rwe, vecs[i].cmd,
              vecs[i].asrc, vecs[i].psrc, vecs[i].rsrc, vecs[i].pwe, 1'b0, exp_ret);
      if (vecs[i].pwe) exp_ret = exp_ret + 1'b1;
    end

    // Illegal opcode: DECODE, then HALT. HALT ignores run and issues no writes.
    drive(1, XX_OP, 4'h0); #1;
    chk("ill fetch state", 32'(state_o), 32'd0);
    drive(1, XX_OP, 4'h0); #1;
    chk("ill decode state", 32'(state_o), 32'd1);
    chk("ill decode illegal", 32'(illegal), 32'd0);
    for (int c = 0; c < 20; c++) begin
      drive(logic'(c[0]), R_OP, 4'h1); #1;
      chk_all($sformatf("halt%0d", c), 3'd5, 0, 0, 4'd0, 0, 0, 0, 0, 1'b1, exp_ret);
    end
    // Asynchronous reset in the middle of a cycle.
    rst_n = 1'b0; #1;
    chk_all("halt_rst", 3'd0, 0, 0, 4'd0, 0, 0, 0, 0, 0, '0);
    drive(0, R_OP, 4'h0);
    rst_n = 1'b1;

    // Reset during LOAD writeback: the write strobe drops at once.
    drive(1, LD_OP, 4'h0);
    drive(1, LD_OP, 4'h0);
    drive(0, LD_OP, 4'h0);
    drive(0, LD_OP, 4'h0);
    drive(0, LD_OP, 4'h0); #1;
    chk("ld wb rf_we", 32'(rf_we), 32'd1);
    rst_n = 1'b0; #1;
    chk_all("wb_rst", 3'd0, 0, 0, 4'd0, 0, 0, 0, 0, 0, '0);
    drive(0, R_OP, 4'h0);
    rst_n = 1'b1;

    // Retired wrap: 16 R-type instructions take the counter 0..15 and back to 0.
    exp_q.push_back('0);
    for (int n = 0; n < 16; n++) begin
      drive(1, R_OP, 4'h0); #1;
      chk($sformatf("wrap%0d state", n), 32'(state_o), 32'd0);
      chk($sformatf("wrap%0d retired", n), 32'(retired), 32'(exp_q.pop_front()));
      exp_q.push_back(CW'(n + 1));
      for (int k = 0; k < 3; k++) drive(1, R_OP, 4'h0);
    end
    drive(0, R_OP, 4'h0); #1;
    chk("wrap end state", 32'(state_o), 32'd0);
    chk("wrap end retired", 32'(retired), 32'(exp_q.pop_front()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uc_multicycle.md
Name: uc_multicycle

Overview:
- Multi-cycle control unit for the RV64 datapath (fd).
- Consumes the datapath's decoded opcode and ALU flags; drives every datapath control input (d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src) and a PC write strobe.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB, replacing free-running step counters with opcode-dependent cycle counts.
- Also keeps a retired-instruction counter.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  when 0, FSM holds in FETCH (no new instruction starts).
- opcode  in  7  instr[6:0] from datapath.
- alu_flags  in  4  datapath ALU flags; bit0 = equal.
- d_mem_we  out  1  data memory write enable.
- rf_we  out  1  register file write enable.
- alu_cmd  out  4  ALU command (encodings in package).
- alu_src  out  1  1 = immediate to ALU B, 0 = rs2.
- pc_src  out  1  1 = branch target, 0 = PC+1.
- rf_src  out  1  1 = memory data to rd, 0 = ALU result.
- pc_we  out  1  one-cycle PC update strobe.
- illegal  out  1  sticky illegal-opcode indicator.
- retired  out  CNT_WIDTH  count of completed instructions.
- state_o  out  3  current state, debug.

Behaviour:
- Reset (async): state=FETCH, class=NONE, illegal=0, retired=0, all control outputs 0, alu_cmd=ALU_ADD.
- Opcode classes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011; anything else is ILLEGAL.
- Class is latched in DECODE and held until the next DECODE. Outputs are a Moore function of (state, latched class), except pc_src, which also uses the live alu_flags[0].
- FETCH:
  - run=1 -> DECODE.
  - run=0 -> stay in FETCH.
  - All control outputs are 0.
- DECODE:
  - Latch class. ILLEGAL -> HALT; otherwise -> EXECUTE.
  - Outputs 0.
- EXECUTE:
  - alu_src=1 for I/LOAD/STORE, 0 for R/BRANCH.
  - alu_cmd=ALU_SUB for BRANCH, ALU_ADD for LOAD/STORE, ALU_FUNCT for R/I.
  - BRANCH: pc_we=1 and pc_src=alu_flags[0], then -> FETCH.
  - LOAD/STORE -> MEM. R/I -> WB.
- MEM:
  - alu_src and alu_cmd are held from EXECUTE.
  - STORE: d_mem_we=1, pc_we=1, then -> FETCH.
  - LOAD -> WB.
- WB:
  - rf_we=1, rf_src=(class==LOAD), pc_we=1, then -> FETCH.
  - alu_src and alu_cmd are held.
- HALT:
  - illegal=1. All write enables and pc_we are 0.
  - Stays in HALT until rst_n is low. run is ignored.
- Latency in cycles (FETCH through final state): BRANCH 3, STORE 4, R/I 4, LOAD 5.
- pc_we is high exactly once per legal instruction, in its last cycle.
- d_mem_we and rf_we are never high in the same cycle, and never high with illegal=1.
- retired increments by 1 on every cycle with pc_we=1. It wraps modulo 2^CNT_WIDTH (all-ones -> 0) with no flag.
- Reset mid-instruction: immediate return to the reset values. No partial write is issued after rst_n falls.
- run deasserted mid-instruction: the current instruction completes, then the FSM holds in FETCH.
- opcode changing outside DECODE has no effect on the sequence.

Decomposition:
- Package uc_pkg:
  - state enum: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.
  - class enum: NONE, R, I, LOAD, STORE, BRANCH, ILLEGAL.
  - opcode constants.
  - alu_cmd constants: ALU_ADD=4'd0, ALU_SUB=4'd1, ALU_FUNCT=4'd2.
- Sub-module opcode_decoder: combinational opcode -> class.
- Counter and FSM stay in uc_multicycle.

Test Plan:
- Reset, then run=1 with R-type 0110011 -> states 0,1,2,4. rf_we=1 and pc_we=1 only in cycle 4. rf_src=0, alu_cmd=2, retired=1.
- LOAD 0000011 -> 5-cycle sequence 0,1,2,3,4. alu_src=1 in cycles 3-5. rf_src=1 and rf_we=1 only in WB. d_mem_we stays 0.
- STORE 0100011 -> d_mem_we=1 and pc_we=1 together in MEM (cycle 4). rf_we stays 0. Next cycle is FETCH.
- BRANCH with alu_flags=4'b0001 -> EXECUTE gives alu_cmd=1, pc_src=1, pc_we=1. Repeat with flags=0 -> pc_src=0. Both take 3 cycles.
- Opcode 7'b1111111 -> HALT after DECODE, illegal=1, no write enables for 20 cycles. Assert rst_n=0 mid-HALT -> illegal=0, state=FETCH immediately (async).
- Preload retired to all-ones via CNT_WIDTH=4 and 16 R-type instructions -> retired wraps to 0. run=0 during WB -> instruction completes, then FSM holds in FETCH.
